// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode constants, decode types and decode helpers for the ID/EX slice.
package riscv_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  typedef enum logic {RUN, BUBBLE} state_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  function automatic imm_t imm_type(input logic [6:0] op);
    return (op == OPC_LOAD || op == OPC_OP_IMM || op == OPC_JALR) ? IMM_I :
           op == OPC_STORE ? IMM_S :
           op == OPC_BRANCH ? IMM_B :
           (op == OPC_LUI || op == OPC_AUIPC) ? IMM_U :
           op == OPC_JAL ? IMM_J : IMM_NONE;
  endfunction
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
  endfunction
  function automatic logic writes_rd(input logic [6:0] op);
    return op == OPC_OP || op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_LUI ||
           op == OPC_AUIPC || op == OPC_JAL || op == OPC_JALR;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX bundle -- IF/ID inputs, register-file port, writeback, flush/stall and registered EX fields; slave = stage, master = surroundings.
interface id_ex_stage_if #(parameter int N = 32);
  logic         id_valid;
  logic [N-1:0] id_pc;
  logic [31:0]  id_instr;
  logic [4:0]   rf_read1, rf_read2;
  logic [N-1:0] rf_data1, rf_data2;
  logic         wb_write;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_data;
  logic         flush;
  logic         stall;
  logic         ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [N-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]   ex_rs1, ex_rs2, ex_rd;
  logic [6:0]   ex_opcode;
  logic [2:0]   ex_funct3;
  logic         ex_funct7b5;
  modport slave (
    input  id_valid, id_pc, id_instr, rf_data1, rf_data2, wb_write, wb_rd, wb_data, flush,
    output rf_read1, rf_read2, stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5
  );
  modport master (
    output id_valid, id_pc, id_instr, rf_data1, rf_data2, wb_write, wb_rd, wb_data, flush,
    input  rf_read1, rf_read2, stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5
  );
endinterface

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate decode (instr in) sign-extended to N bits (imm out).
module imm_gen import riscv_pkg::*; #(parameter int N = 32) (
  input  logic [31:0]  instr,
  output logic [N-1:0] imm
);
  imm_t t;
  logic signed [31:0] v;
  assign t = imm_type(instr[6:0]);
  always_comb begin
    v = t == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
        t == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
        t == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
        t == IMM_U ? {instr[31:12], 12'b0} :
        t == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'sd0;
  end
  assign imm = N'(v);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, operand bypass/x0 forcing, load-use interlock (RUN/BUBBLE) and ID/EX pipeline register; ports clk, rst (async, active-high), bus (slave).
module id_ex_stage import riscv_pkg::*; #(parameter int N = 32) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  state_t state;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic [N-1:0] imm, rs1_val, rs2_val;
  logic load_use, bubble;
  assign op = bus.id_instr[6:0];
  assign rs1 = bus.id_instr[19:15];
  assign rs2 = bus.id_instr[24:20];
  assign rd = bus.id_instr[11:7];
  assign bus.rf_read1 = rs1;
  assign bus.rf_read2 = rs2;
  imm_gen #(.N(N)) u_imm (.instr(bus.id_instr), .imm(imm));
  // x0 reads zero even if a writeback targets x0 or the file returns garbage
  assign rs1_val = rs1 == 5'd0 ? '0 : (bus.wb_write && bus.wb_rd == rs1) ? bus.wb_data : bus.rf_data1;
  assign rs2_val = rs2 == 5'd0 ? '0 : (bus.wb_write && bus.wb_rd == rs2) ? bus.wb_data : bus.rf_data2;
  assign load_use = bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                    ((uses_rs1(op) && rs1 == bus.ex_rd) || (uses_rs2(op) && rs2 == bus.ex_rd));
  // the bubble cycle re-presents the held instruction against an empty EX, so stall is masked there
  assign bus.stall = state == RUN && load_use && !bus.flush;
  assign bubble = bus.flush || !bus.id_valid || bus.stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      bus.ex_valid <= 1'b0;
      bus.ex_mem_read <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_pc <= '0;
      bus.ex_rs1_val <= '0;
      bus.ex_rs2_val <= '0;
      bus.ex_imm <= '0;
      bus.ex_rs1 <= '0;
      bus.ex_rs2 <= '0;
      bus.ex_rd <= '0;
      bus.ex_opcode <= '0;
      bus.ex_funct3 <= '0;
      bus.ex_funct7b5 <= 1'b0;
    end else begin
      state <= bus.stall ? BUBBLE : RUN;
      bus.ex_valid <= !bubble;
      bus.ex_mem_read <= !bubble && op == OPC_LOAD;
      bus.ex_mem_write <= !bubble && op == OPC_STORE;
      bus.ex_reg_write <= !bubble && writes_rd(op) && rd != 5'd0;
      bus.ex_pc <= bus.id_pc;
      bus.ex_rs1_val <= rs1_val;
      bus.ex_rs2_val <= rs2_val;
      bus.ex_imm <= imm;
      bus.ex_rs1 <= rs1;
      bus.ex_rs2 <= rs2;
      bus.ex_rd <= rd;
      bus.ex_opcode <= op;
      bus.ex_funct3 <= bus.id_instr[14:12];
      bus.ex_funct7b5 <= bus.id_instr[30];
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  id_ex_stage_if #(.N(32)) bus ();
  id_ex_stage #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [31:0] ADDI_M1   = 32'hFFF00293;
  localparam logic [31:0] ADD_312   = 32'h002081B3;
  localparam logic [31:0] ADD_302   = 32'h002001B3;
  localparam logic [31:0] SW_M4     = 32'hFE20AE23;
  localparam logic [31:0] BEQ_M8    = 32'hFE000CE3;
  localparam logic [31:0] JAL_800   = 32'h001000EF;
  localparam logic [31:0] LW_7      = 32'h0000A383;
  localparam logic [31:0] ADD_871   = 32'h00138433;
  localparam logic [31:0] LUI_7     = 32'h000383B7;
  localparam logic [31:0] LW_0      = 32'h0003A003;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.id_valid = v;
    bus.id_pc = pc;
    bus.id_instr = instr;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_pc = '0;
    bus.id_instr = '0;
    bus.rf_data1 = '0;
    bus.rf_data2 = '0;
    bus.wb_write = 1'b0;
    bus.wb_rd = '0;
    bus.wb_data = '0;
    bus.flush = 1'b0;
    repeat (2) tick;
    check("rst_valid", 32'(bus.ex_valid), 0);
    check("rst_pc", bus.ex_pc, 0);
    check("rst_stall", 32'(bus.stall), 0);
    rst = 1'b0;
    bus.rf_data1 = 32'h1234;
    drive(1, 32'h10, ADDI_M1);
    check("addi_read1", 32'(bus.rf_read1), 0);
    tick;
    check("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
    check("addi_rd", 32'(bus.ex_rd), 5);
    check("addi_rw", 32'(bus.ex_reg_write), 1);
    check("addi_rs1v", bus.ex_rs1_val, 0);
    check("addi_valid", 32'(bus.ex_valid), 1);
    check("addi_pc", bus.ex_pc, 32'h10);
    bus.rf_data1 = 32'h11;
    bus.rf_data2 = 32'h22;
    bus.wb_write = 1'b1;
    bus.wb_rd = 5'd1;
    bus.wb_data = 32'hAA;
    drive(1, 32'h14, ADD_312);
    check("add_read2", 32'(bus.rf_read2), 2);
    tick;
    check("byp_rs1v", bus.ex_rs1_val, 32'hAA);
    check("byp_rs2v", bus.ex_rs2_val, 32'h22);
    check("add_opc", 32'(bus.ex_opcode), 32'h33);
    bus.wb_rd = 5'd0;
    tick;
    check("wb0_rs1v", bus.ex_rs1_val, 32'h11);
    drive(1, 32'h18, ADD_302);
    tick;
    check("x0_rs1v", bus.ex_rs1_val, 0);
    check("x0_rs2v", bus.ex_rs2_val, 32'h22);
    bus.wb_write = 1'b0;
    drive(1, 32'h1C, SW_M4);
    tick;
    check("sw_imm", bus.ex_imm, 32'hFFFFFFFC);
    check("sw_mw", 32'(bus.ex_mem_write), 1);
    check("sw_rw", 32'(bus.ex_reg_write), 0);
    check("sw_f3", 32'(bus.ex_funct3), 2);
    drive(1, 32'h20, BEQ_M8);
    tick;
    check("beq_imm", bus.ex_imm, 32'hFFFFFFF8);
    drive(1, 32'h24, JAL_800);
    tick;
    check("jal_imm", bus.ex_imm, 32'h800);
    check("jal_rw", 32'(bus.ex_reg_write), 1);
    drive(0, 32'h28, ADDI_M1);
    tick;
    check("inv_valid", 32'(bus.ex_valid), 0);
    check("inv_rw", 32'(bus.ex_reg_write), 0);
    drive(1, 32'h100, LW_7);
    tick;
    check("lw_mr", 32'(bus.ex_mem_read), 1);
    check("lw_rd", 32'(bus.ex_rd), 7);
    drive(1, 32'h104, ADD_871);
    check("lu_stall", 32'(bus.stall), 1);
    tick;
    check("lu_bub_valid", 32'(bus.ex_valid), 0);
    check("lu_bub_mr", 32'(bus.ex_mem_read), 0);
    check("lu_bub_stall", 32'(bus.stall), 0);
    tick;
    check("lu_add_valid", 32'(bus.ex_valid), 1);
    check("lu_add_rd", 32'(bus.ex_rd), 8);
    check("lu_add_pc", bus.ex_pc, 32'h104);
    check("lu_add_stall", 32'(bus.stall), 0);
    drive(1, 32'h108, LW_7);
    tick;
    drive(1, 32'h10C, LUI_7);
    check("lui_stall", 32'(bus.stall), 0);
    tick;
    check("lui_imm", bus.ex_imm, 32'h00038000);
    check("lui_valid", 32'(bus.ex_valid), 1);
    drive(1, 32'h110, LW_0);
    tick;
    check("lw0_rw", 32'(bus.ex_reg_write), 0);
    drive(1, 32'h114, ADD_871);
    check("lw0_stall", 32'(bus.stall), 0);
    drive(1, 32'h118, LW_7);
    tick;
    bus.flush = 1'b1;
    drive(1, 32'h11C, ADD_871);
    check("fl_stall", 32'(bus.stall), 0);
    tick;
    check("fl_valid", 32'(bus.ex_valid), 0);
    bus.flush = 1'b0;
    #1;
    check("fl_after_stall", 32'(bus.stall), 0);
    tick;
    check("fl_add_valid", 32'(bus.ex_valid), 1);
    check("fl_add_rd", 32'(bus.ex_rd), 8);
    drive(1, 32'h200, LW_7);
    tick;
    drive(1, 32'h204, ADD_871);
    check("rb_stall", 32'(bus.stall), 1);
    tick;
    check("rb_bub_valid", 32'(bus.ex_valid), 0);
    #2;
    rst = 1'b1;
    #1;
    check("rb_rst_pc", bus.ex_pc, 0);
    check("rb_rst_valid", 32'(bus.ex_valid), 0);
    check("rb_rst_rd", 32'(bus.ex_rd), 0);
    check("rb_rst_stall", 32'(bus.stall), 0);
    #1;
    rst = 1'b0;
    tick;
    check("rb_add_valid", 32'(bus.ex_valid), 1);
    check("rb_add_rd", 32'(bus.ex_rd), 8);
    check("rb_add_pc", bus.ex_pc, 32'h204);
    check("rb_add_stall", 32'(bus.stall), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  clock, rising edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid  input  1  IF/ID holds a valid instruction.
REQ-005 SHALL have ports id_pc, id_instr  input  N, 32  PC and instruction from IF/ID.
REQ-006 SHALL have ports rf_read1, rf_read2  output  5  register-file read addresses (instr[19:15], instr[24:20]).
REQ-007 SHALL have ports rf_data1, rf_data2  input  N  register-file combinational read data.
REQ-008 SHALL have ports wb_write, wb_rd, wb_data  input  1, 5, N  writeback port, same signals driving the register file.
REQ-009 SHALL have port flush  input  1  taken branch/jump resolved in EX.
REQ-010 SHALL have port stall  output  1  hold PC and IF/ID this cycle.
REQ-011 SHALL have ports ex_valid, ex_mem_read, ex_mem_write, ex_reg_write  output  1 each  EX control.
REQ-012 SHALL have ports ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  N each  EX operands.
REQ-013 SHALL have ports ex_rs1, ex_rs2, ex_rd  output  5 each; ex_opcode 7; ex_funct3 3; ex_funct7b5 1.

Function
REQ-014 SHALL decode opcode into imm type: I (LOAD, OP_IMM, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); other opcodes imm=0.
REQ-015 SHALL sign-extend all immediates to N bits per RV32I encoding; B/J LSB=0; U lower 12 bits=0.
REQ-016 SHALL treat rs1 used for all opcodes except LUI, AUIPC, JAL; rs2 used only for OP, STORE, BRANCH.
REQ-017 SHALL bypass: operand value = wb_data when wb_write=1, wb_rd!=0 and wb_rd equals the source index; else rf_data.
REQ-018 SHALL force operand value 0 when source index is 0, regardless of bypass or rf_data.
REQ-019 SHALL detect load-use: ex_valid=1, ex_mem_read=1, ex_rd!=0, ex_rd matches a used source of the id instruction, id_valid=1.
REQ-020 SHALL implement FSM RUN/BUBBLE: RUN on load-use -> BUBBLE; BUBBLE -> RUN unconditionally next cycle.
REQ-021 SHALL assert stall combinationally in the cycle load-use is detected in RUN; stall=0 in BUBBLE.
REQ-022 SHALL on a load-use edge load a bubble: ex_valid=0, ex_mem_read=0, ex_mem_write=0, ex_reg_write=0; datapath fields don't-care.
REQ-023 SHALL otherwise register all ex_* fields from ID on each rising edge, latency 1 cycle.
REQ-024 SHALL register ex_reg_write=1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR with rd!=0; ex_mem_read for LOAD; ex_mem_write for STORE.
REQ-025 SHALL give flush priority over load-use: flush=1 loads a bubble, forces stall=0, FSM -> RUN.
REQ-026 SHALL load a bubble when id_valid=0; control bits never assert for invalid slots.

Reset
REQ-027 SHALL on rst=1 immediately clear all ex_* registers to 0 and FSM to RUN; stall=0 while reset asserted.
REQ-028 SHALL discard any pending bubble on reset mid-stall; first post-reset edge loads ID normally.

Structure
REQ-029 SHALL place opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, OP 0110011, OP_IMM 0010011) and the RUN/BUBBLE state type in shared package riscv_pkg.
REQ-030 SHALL implement immediate generation as combinational sub-module imm_gen (instr in, N-bit imm out).

Verification
REQ-031 SHALL test ADDI x5,x0,-1 (0xFFF00293) -> next edge ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1, ex_rs1_val=0.
REQ-032 SHALL test bypass: ID ADD x3,x1,x2, rf_data1=0x11, wb_write=1 wb_rd=1 wb_data=0xAA -> ex_rs1_val=0xAA; same with wb_rd=0 -> 0 forced for x0 source only.
REQ-033 SHALL test load-use: EX holds LW x7, ID ADD x8,x7,x1 -> stall=1 one cycle, ex_valid=0 next edge, ADD enters EX following edge with stall=0.
REQ-034 SHALL test no false stall: EX LW x7, ID LUI x7 or LW x0 in EX -> stall=0.
REQ-035 SHALL test flush and load-use same cycle -> stall=0, ex_valid=0, FSM RUN.
REQ-036 SHALL test rst asserted mid-BUBBLE between edges -> all ex_* 0 immediately, stall=0, normal load after release.
